// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider: one quotient bit per cycle, signed fix-up,
// divide-by-zero shortcut and annulment; result is {remainder, quotient}.
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] v);
        return -v;
    endfunction

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic take);
        return take ? neg(v) : v;
    endfunction

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic                neg_dvd_q, neg_dvd_d;
    logic                neg_dvs_q, neg_dvs_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     shifted;
    logic                trial_ge;
    logic [DATA_W-1:0]   trial;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    // Remainder stays below the divisor, so a successful trial always fits in 32 bits.
    assign shifted  = {rem_q, dvd_q[DATA_W-1]};
    assign trial_ge = shifted >= {1'b0, dvs_q};
    assign trial    = shifted[DATA_W-1:0] - dvs_q;
    assign quot_fix = mag(quot_q, neg_dvd_q ^ neg_dvs_q);
    assign rem_fix  = mag(rem_q, neg_dvd_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        neg_dvd_d = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                        neg_dvs_d = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
                        dvd_d     = mag(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[DATA_W-1]);
                        dvs_d     = mag(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[DATA_W-1]);
                        rem_d     = '0;
                        quot_d    = '0;
                        cnt_d     = '0;
                    end
                end
            end
            BYZERO: begin
                result_d = '0;
                if (bus.annul_i) begin
                    state_d = FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d = END;
                    ready_d = 1'b1;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != 6'd32) begin
                    dvd_d  = {dvd_q[DATA_W-2:0], 1'b0};
                    rem_d  = trial_ge ? trial : shifted[DATA_W-1:0];
                    quot_d = {quot_q[DATA_W-2:0], trial_ge};
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    state_d  = END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the divider: stimulus pushes expected results and
// ready edges into a scoreboard; a monitor checks them when ready_o rises.
module tb_div;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic prev_ready = 1'b0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    div_if bus();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && !prev_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ready: got result %h with nothing outstanding", bus.result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", bus.result_o, e.res);
                chk("ready_edge", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_ready = (bus.ready_o === 1'b1);
    end

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    task automatic wait_ready(input int lat, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lat + 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.opdata1_i = 32'hDEAD_BEEF;
                bus.opdata2_i = 32'h0000_0003;
            end
            if (bus.ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: ready_o not seen within %0d cycles", lat + 6);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        exp_t e;
        bit   seen;
        issue(sgn, a, b);
        e.res = exp;
        e.cyc = cyc + lat;
        sb.push_back(e);
        wait_ready(lat, seen);
        if (seen) begin
            repeat (2) begin
                @(negedge clk);
                chk("hold_ready", 64'(bus.ready_o), 64'd1);
                chk("hold_result", bus.result_o, exp);
            end
            bus.start_i = 1'b0;
            @(negedge clk);
            chk("release_ready", 64'(bus.ready_o), 64'd0);
            chk("release_result", bus.result_o, 64'd0);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   seen;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34);
        run_op(1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
        run_op(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        run_op(1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF, 34);
        run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run_op(1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 34);
        run_op(1'b0, 32'd7,          32'd9,        64'h00000007_00000000, 34);
        run_op(1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 34);
        run_op(1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 2);

        // Annul at iteration 10: nothing may complete afterwards.
        issue(1'b0, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        chk("annul_on_ready", 64'(bus.ready_o), 64'd0);
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

        // Annul while in BYZERO.
        issue(1'b0, 32'd5, 32'd0);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        chk("annul_byzero_ready", 64'(bus.ready_o), 64'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset at iteration 20.
        issue(1'b0, 32'd100, 32'd7);
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        // Asynchronous reset while a result is being held.
        issue(1'b0, 32'd100, 32'd7);
        e.res = 64'h00000002_0000000E;
        e.cyc = cyc + 34;
        sb.push_back(e);
        wait_ready(34, seen);
        #2 rst = 1'b1;
        #1;
        chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_end_result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
